// File: rtl/cache_ctrl_assoc.sv
// Controller for an N-way set-associative, write-back, write-allocate cache over a
// fixed-latency banked memory: victim selection, write-back, pipelined line fill.
module cache_ctrl_assoc #(
  parameter int WAYS    = 2,
  parameter int WORDS   = 4,
  parameter int MEM_LAT = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rd,
  input  logic                     wr,
  input  logic [WAYS-1:0]          hit_way,
  input  logic [WAYS-1:0]          valid_way,
  input  logic [WAYS-1:0]          dirty_way,
  input  logic                     cache_err,
  input  logic                     mem_err,
  input  logic                     mem_stall,
  output logic [WAYS-1:0]          way_sel,
  output logic                     comp,
  output logic                     cache_wr,
  output logic [$clog2(WORDS)-1:0] cache_off,
  output logic                     mem_rd,
  output logic                     mem_wr,
  output logic [$clog2(WORDS)-1:0] mem_off,
  output logic                     stall,
  output logic                     done,
  output logic                     cache_hit,
  output logic                     err
);

  localparam int OW = $clog2(WORDS);
  localparam int CW = OW + 1;
  localparam int VW = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [2:0] {IDLE, WB, FILL, FINAL, ERR} state_t;

  state_t                      state, state_nxt;
  logic [WAYS-1:0]             vic, vic_nxt;
  logic [VW-1:0]               vp, vp_nxt;
  logic                        all_vld, all_vld_nxt;
  logic                        req_wr, req_wr_nxt;
  logic [CW-1:0]               cnt, cnt_nxt;
  logic [MEM_LAT-1:0]          trk_vld, trk_vld_nxt;
  logic [MEM_LAT-1:0][OW-1:0]  trk_off, trk_off_nxt;

  logic [WAYS-1:0] hit_vec;
  logic            hit;
  logic            flt;
  logic            issue;
  logic            inv_found;
  logic [VW-1:0]   vic_idx;
  logic [WAYS-1:0] vic_new;

  assign hit_vec = hit_way & valid_way;
  assign hit     = |hit_vec;
  assign flt     = cache_err | mem_err;
  assign issue   = (state == FILL) && (cnt < CW'(WORDS)) && !mem_stall;

  // Victim: lowest-index invalid way, otherwise the round-robin pointer.
  always_comb begin
    inv_found = 1'b0;
    vic_idx   = vp;
    for (int w = 0; w < WAYS; w++) begin
      if (!valid_way[w] && !inv_found) begin
        inv_found = 1'b1;
        vic_idx   = VW'(w);
      end
    end
    vic_new = WAYS'(1) << vic_idx;
  end

  // Return tracker shifts every FILL cycle regardless of mem_stall; anything
  // in flight is dropped when FILL is left, so stale returns never write.
  always_comb begin
    trk_vld_nxt = '0;
    trk_off_nxt = '0;
    if (state == FILL && !flt) begin
      trk_vld_nxt[0] = issue;
      trk_off_nxt[0] = cnt[OW-1:0];
      for (int s = 1; s < MEM_LAT; s++) begin
        trk_vld_nxt[s] = trk_vld[s-1];
        trk_off_nxt[s] = trk_off[s-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      vic     <= '0;
      vp      <= '0;
      all_vld <= 1'b0;
      req_wr  <= 1'b0;
      cnt     <= '0;
      trk_vld <= '0;
      trk_off <= '0;
    end else begin
      state   <= state_nxt;
      vic     <= vic_nxt;
      vp      <= vp_nxt;
      all_vld <= all_vld_nxt;
      req_wr  <= req_wr_nxt;
      cnt     <= cnt_nxt;
      trk_vld <= trk_vld_nxt;
      trk_off <= trk_off_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    vic_nxt     = vic;
    vp_nxt      = vp;
    all_vld_nxt = all_vld;
    req_wr_nxt  = req_wr;
    cnt_nxt     = cnt;
    way_sel     = '0;
    comp        = 1'b0;
    cache_wr    = 1'b0;
    cache_off   = '0;
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;
    mem_off     = '0;
    stall       = 1'b0;
    done        = 1'b0;
    cache_hit   = 1'b0;
    err         = 1'b0;
    case (state)
      IDLE: begin
        comp    = 1'b1;
        way_sel = '1;
        if (rd || wr) begin
          if ((rd && wr) || cache_err) begin
            done = 1'b1;
            err  = 1'b1;
          end else if (hit) begin
            way_sel   = hit_vec;
            cache_wr  = wr;
            done      = 1'b1;
            cache_hit = 1'b1;
          end else begin
            vic_nxt     = vic_new;
            all_vld_nxt = &valid_way;
            req_wr_nxt  = wr;
            cnt_nxt     = '0;
            state_nxt   = (valid_way[vic_idx] && dirty_way[vic_idx]) ? WB : FILL;
          end
        end
      end
      WB: begin
        way_sel   = vic;
        stall     = 1'b1;
        cache_off = cnt[OW-1:0];
        mem_off   = cnt[OW-1:0];
        if (!mem_stall) begin
          mem_wr  = 1'b1;
          cnt_nxt = cnt + 1'b1;
          if (cnt == CW'(WORDS - 1)) begin
            cnt_nxt   = '0;
            state_nxt = FILL;
          end
        end
        if (flt) state_nxt = ERR;
      end
      FILL: begin
        way_sel = vic;
        stall   = 1'b1;
        if (issue) begin
          mem_rd  = 1'b1;
          mem_off = cnt[OW-1:0];
          cnt_nxt = cnt + 1'b1;
        end
        if (trk_vld[MEM_LAT-1]) begin
          cache_wr  = 1'b1;
          cache_off = trk_off[MEM_LAT-1];
        end
        if (flt)
          state_nxt = ERR;
        else if (cnt_nxt == CW'(WORDS) && trk_vld_nxt == '0)
          state_nxt = FINAL;
      end
      FINAL: begin
        comp    = 1'b1;
        way_sel = vic;
        if (flt) begin
          state_nxt = ERR;
        end else begin
          cache_wr  = req_wr;
          done      = 1'b1;
          state_nxt = IDLE;
          if (all_vld) vp_nxt = (WAYS == 1) ? '0 : vp + 1'b1;
        end
      end
      ERR: begin
        done      = 1'b1;
        err       = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Outputs are forced low for as long as reset is held.
    if (rst) begin
      way_sel   = '0;
      comp      = 1'b0;
      cache_wr  = 1'b0;
      cache_off = '0;
      mem_rd    = 1'b0;
      mem_wr    = 1'b0;
      mem_off   = '0;
      stall     = 1'b0;
      done      = 1'b0;
      cache_hit = 1'b0;
      err       = 1'b0;
    end
  end

endmodule

// File: tb/tb_cache_ctrl_assoc.sv
// Directed cycle-by-cycle vectors for cache_ctrl_assoc with default parameters.
module tb_cache_ctrl_assoc;

  logic       clk = 1'b0;
  logic       rst, rd, wr, cache_err, mem_err, mem_stall;
  logic [1:0] hit_way, valid_way, dirty_way;
  logic [1:0] way_sel, cache_off, mem_off;
  logic       comp, cache_wr, mem_rd, mem_wr, stall, done, cache_hit, err;

  always #5 clk = ~clk;

  cache_ctrl_assoc #(.WAYS(2), .WORDS(4), .MEM_LAT(2)) dut (
    .clk(clk), .rst(rst), .rd(rd), .wr(wr),
    .hit_way(hit_way), .valid_way(valid_way), .dirty_way(dirty_way),
    .cache_err(cache_err), .mem_err(mem_err), .mem_stall(mem_stall),
    .way_sel(way_sel), .comp(comp), .cache_wr(cache_wr), .cache_off(cache_off),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_off(mem_off),
    .stall(stall), .done(done), .cache_hit(cache_hit), .err(err)
  );

  typedef struct {
    string      name;
    logic       r, rdi, wri;
    logic [1:0] hw, vw, dw;
    logic       ce, me, ms;
    logic [13:0] exp;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Expected output word: {way_sel, comp, cache_wr, cache_off, mem_rd, mem_wr, mem_off, stall, done, cache_hit, err}
  function automatic logic [13:0] o(input logic [1:0] ws, input logic cp, cw, input logic [1:0] co,
                                    input logic mr, mw, input logic [1:0] mo,
                                    input logic st, dn, ht, er);
    return {ws, cp, cw, co, mr, mw, mo, st, dn, ht, er};
  endfunction

  function automatic vec_t mk(input string nm, input logic r, rdi, wri, input logic [1:0] hw, vw, dw,
                              input logic ce, me, ms, input logic [13:0] e);
    vec_t x;
    x.name = nm; x.r = r; x.rdi = rdi; x.wri = wri;
    x.hw = hw; x.vw = vw; x.dw = dw; x.ce = ce; x.me = me; x.ms = ms; x.exp = e;
    return x;
  endfunction

  task automatic run(input vec_t x);
    logic [13:0] act;
    rst = x.r; rd = x.rdi; wr = x.wri;
    hit_way = x.hw; valid_way = x.vw; dirty_way = x.dw;
    cache_err = x.ce; mem_err = x.me; mem_stall = x.ms;
    @(negedge clk);
    act = {way_sel, comp, cache_wr, cache_off, mem_rd, mem_wr, mem_off, stall, done, cache_hit, err};
    n_vec++;
    if (act !== x.exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", x.name, act, x.exp);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic step(input string nm, input logic r, rdi, wri, input logic [1:0] hw, vw, dw,
                      input logic ce, me, ms, input logic [13:0] e);
    run(mk(nm, r, rdi, wri, hw, vw, dw, ce, me, ms, e));
  endtask

  // Miss with no stalls: request cycle, optional 4-cycle write-back, 6-cycle fill
  // (issues on fill cycles 0-3, returns on fill cycles 2-5), FINAL, then idle.
  task automatic add_miss(input string nm, input logic rdi, wri, input logic [1:0] hw, vw, dw,
                          input logic [1:0] vs, input logic dirty);
    logic [13:0] idl;
    int c;
    idl = o(2'b11, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    c = 0;
    tbl.push_back(mk($sformatf("%s_c%0d", nm, c), 0, rdi, wri, hw, vw, dw, 0, 0, 0, idl));
    if (dirty) begin
      for (int k = 0; k < 4; k++) begin
        c++;
        tbl.push_back(mk($sformatf("%s_c%0d", nm, c), 0, rdi, wri, hw, vw, dw, 0, 0, 0,
                         o(vs, 0, 0, 2'(k), 0, 1, 2'(k), 1, 0, 0, 0)));
      end
    end
    for (int f = 0; f < 6; f++) begin
      logic mr, cw;
      logic [1:0] mo, co;
      c++;
      mr = (f < 4);
      mo = mr ? 2'(f) : 2'd0;
      cw = (f >= 2);
      co = cw ? 2'(f - 2) : 2'd0;
      tbl.push_back(mk($sformatf("%s_c%0d", nm, c), 0, rdi, wri, hw, vw, dw, 0, 0, 0,
                       o(vs, 0, cw, co, mr, 0, mo, 1, 0, 0, 0)));
    end
    c++;
    tbl.push_back(mk($sformatf("%s_c%0d_final", nm, c), 0, rdi, wri, hw, vw, dw, 0, 0, 0,
                     o(vs, 1, wri, 0, 0, 0, 0, 0, 1, 0, 0)));
    tbl.push_back(mk($sformatf("%s_after", nm), 0, 0, 0, 0, 0, 0, 0, 0, 0, idl));
  endtask

  initial begin
    logic [13:0] z, idl, fv, sv;
    logic [13:0] stall_exp[10];
    logic        stall_ms[10];
    z   = '0;
    idl = o(2'b11, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    tbl.push_back(mk("reset",      1, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, z));
    tbl.push_back(mk("idle",       0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, idl));
    tbl.push_back(mk("rd_hit_w1",  0, 1, 0, 2'b10, 2'b11, 2'b00, 0, 0, 0, o(2'b10, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0)));
    tbl.push_back(mk("idle2",      0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, idl));
    tbl.push_back(mk("wr_hit_w0",  0, 0, 1, 2'b01, 2'b01, 2'b01, 0, 0, 0, o(2'b01, 1, 1, 0, 0, 0, 0, 0, 1, 1, 0)));
    tbl.push_back(mk("rd_and_wr",  0, 1, 1, 2'b01, 2'b11, 2'b00, 0, 0, 0, o(2'b11, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1)));
    tbl.push_back(mk("idle_cerr",  0, 1, 0, 2'b01, 2'b11, 2'b00, 1, 0, 0, o(2'b11, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1)));
    tbl.push_back(mk("idle3",      0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, idl));
    // tag match on an invalid way is a miss; way 0 invalid is the victim, vp stays 0
    add_miss("clean_w0", 1, 0, 2'b01, 2'b10, 2'b10, 2'b01, 0);
    // all valid, vp=0 -> victim way 0, vp advances to 1
    add_miss("clean_allv", 1, 0, 2'b00, 2'b11, 2'b00, 2'b01, 0);
    // all valid, vp=1, way 1 dirty -> write-back then fill; vp wraps to 0
    add_miss("dirty_wr", 0, 1, 2'b00, 2'b11, 2'b10, 2'b10, 1);

    for (int i = 0; i < tbl.size(); i++) run(tbl[i]);

    // Clean miss, vp=0, mem_stall on cycles 2-3: issues on 1,4,5,6, returns on 3,6,7,8.
    fv = o(2'b01, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    stall_exp[0] = idl;
    stall_exp[1] = o(2'b01, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0);
    stall_exp[2] = fv;
    stall_exp[3] = o(2'b01, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0);
    stall_exp[4] = o(2'b01, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0);
    stall_exp[5] = o(2'b01, 0, 0, 0, 1, 0, 2, 1, 0, 0, 0);
    stall_exp[6] = o(2'b01, 0, 1, 1, 1, 0, 3, 1, 0, 0, 0);
    stall_exp[7] = o(2'b01, 0, 1, 2, 0, 0, 0, 1, 0, 0, 0);
    stall_exp[8] = o(2'b01, 0, 1, 3, 0, 0, 0, 1, 0, 0, 0);
    stall_exp[9] = o(2'b01, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    for (int c = 0; c < 10; c++) stall_ms[c] = (c == 2 || c == 3);
    for (int c = 0; c < 10; c++)
      step($sformatf("mstall_c%0d", c), 0, 1, 0, 2'b00, 2'b11, 2'b00, 0, 0, stall_ms[c], stall_exp[c]);
    step("mstall_after", 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, idl);

    // mem_err during FILL (victim way 1 invalid): ERR next cycle, then a hit is accepted.
    step("merr_c0", 0, 1, 0, 2'b00, 2'b01, 2'b00, 0, 0, 0, idl);
    step("merr_c1", 0, 1, 0, 2'b00, 2'b01, 2'b00, 0, 0, 0, o(2'b10, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0));
    step("merr_c2", 0, 1, 0, 2'b00, 2'b01, 2'b00, 0, 1, 0, o(2'b10, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0));
    step("merr_err", 0, 1, 0, 2'b00, 2'b01, 2'b00, 0, 0, 0, o(2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1));
    step("merr_hit", 0, 1, 0, 2'b01, 2'b01, 2'b00, 0, 0, 0, o(2'b01, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0));
    step("merr_idle1", 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, idl);
    step("merr_idle2", 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, idl);

    // Reset mid-WB (vp=1, way 1 dirty), then a full-valid miss must pick way 0 again.
    sv = o(2'b10, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0);
    step("rstwb_c0", 0, 0, 1, 2'b00, 2'b11, 2'b10, 0, 0, 0, idl);
    step("rstwb_c1", 0, 0, 1, 2'b00, 2'b11, 2'b10, 0, 0, 0, sv);
    step("rstwb_rst0", 1, 0, 1, 2'b00, 2'b11, 2'b10, 0, 0, 0, z);
    step("rstwb_rst1", 1, 0, 1, 2'b00, 2'b11, 2'b10, 0, 0, 0, z);
    for (int c = 0; c < 3; c++)
      step($sformatf("rstwb_idle%0d", c), 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, idl);
    step("rstwb_miss_c0", 0, 1, 0, 2'b00, 2'b11, 2'b00, 0, 0, 0, idl);
    step("rstwb_miss_c1", 0, 1, 0, 2'b00, 2'b11, 2'b00, 0, 0, 0, o(2'b01, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
